// File: rtl/uart_lite.sv
// uart_lite: 8N1 UART with AXI4-Lite register interface, TX/RX FIFOs and interrupt
// Ports: clk_i clock; rst_i asynchronous active-low reset;
//        cfg_aw*/cfg_w*/cfg_b* AXI4-Lite write channels, cfg_ar*/cfg_r* read channels;
//        rx_i serial input (idle high); tx_o serial output (idle high); intr_o one-clock interrupt pulse.
module uart_lite #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 125000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_awvalid_i,
    input  logic [31:0] cfg_awaddr_i,
    output logic        cfg_awready_o,
    input  logic        cfg_wvalid_i,
    input  logic [31:0] cfg_wdata_i,
    input  logic [3:0]  cfg_wstrb_i,
    output logic        cfg_wready_o,
    output logic        cfg_bvalid_o,
    output logic [1:0]  cfg_bresp_o,
    input  logic        cfg_bready_i,
    input  logic        cfg_arvalid_i,
    input  logic [31:0] cfg_araddr_i,
    output logic        cfg_arready_o,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic [1:0]  cfg_rresp_o,
    input  logic        cfg_rready_i,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        intr_o
);
    localparam int BIT_CLKS = CLK_FREQ / BAUDRATE;
    localparam int CW = $clog2(BIT_CLKS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] BIT_END = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BIT_CLKS / 2 - 1);
    localparam logic [PW-1:0] DEPTH = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t rx_st, rx_st_n;
    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp, tx_lvl, rx_lvl;
    logic [7:0] tx_mem [FIFO_DEPTH];
    logic [7:0] rx_mem [FIFO_DEPTH];
    logic [1:0] wa, ra, rx_s;
    logic wr_acc, rd_acc, ctl_wr, tx_rst, rx_rst, tx_push, rx_pop, st_rd;
    logic ie, oe, fe;
    logic tx_busy, tx_end, tx_load;
    logic [3:0] tx_bit;
    logic [CW-1:0] tx_clk, rx_clk;
    logic [9:0] tx_sh;
    logic rx_q, rx_fall, rx_tick, rx_done, rx_ok, rx_push;
    logic [2:0] rx_bit;
    logic [7:0] rx_sh, status, rd_byte;
    logic unused_ok;

    assign wa = cfg_awaddr_i[3:2];
    assign ra = cfg_araddr_i[3:2];
    assign wr_acc = cfg_awvalid_i & cfg_wvalid_i & ~cfg_bvalid_o;
    assign rd_acc = cfg_arvalid_i & ~cfg_rvalid_o;
    assign cfg_awready_o = wr_acc;
    assign cfg_wready_o = wr_acc;
    assign cfg_arready_o = rd_acc;
    assign cfg_bresp_o = 2'b00;
    assign cfg_rresp_o = 2'b00;
    assign unused_ok = ^{cfg_awaddr_i[31:4], cfg_awaddr_i[1:0], cfg_araddr_i[31:4],
                         cfg_araddr_i[1:0], cfg_wdata_i[31:8], cfg_wstrb_i[3:1]};

    assign tx_lvl = tx_wp - tx_rp;
    assign rx_lvl = rx_wp - rx_rp;
    assign ctl_wr = wr_acc & (wa == 2'd3) & cfg_wstrb_i[0];
    assign tx_rst = ctl_wr & cfg_wdata_i[0];
    assign rx_rst = ctl_wr & cfg_wdata_i[1];
    assign tx_push = wr_acc & (wa == 2'd1) & cfg_wstrb_i[0] & (tx_lvl != DEPTH);
    assign rx_pop = rd_acc & (ra == 2'd0) & (rx_lvl != '0);
    assign st_rd = rd_acc & (ra == 2'd2);
    assign status = {1'b0, fe, oe, ie, tx_lvl == DEPTH, tx_lvl == '0, rx_lvl == DEPTH, rx_lvl != '0};
    assign rd_byte = (ra == 2'd0 && rx_lvl != '0) ? rx_mem[rx_rp[AW-1:0]] : 8'h00;

    // A new byte is loaded in the same cycle the previous stop bit ends, so frames run back to back.
    assign tx_end = tx_busy & (tx_clk == BIT_END) & (tx_bit == 4'd9);
    assign tx_load = (~tx_busy | tx_end) & (tx_lvl != '0) & ~tx_rst;
    assign tx_o = tx_sh[0];

    assign rx_fall = rx_q & ~rx_s[1];
    assign rx_tick = rx_clk == ((rx_st == R_START) ? HALF_END : BIT_END);
    assign rx_done = (rx_st == R_STOP) & rx_tick;
    assign rx_ok = rx_done & rx_s[1];
    assign rx_push = rx_ok & (rx_lvl != DEPTH) & ~rx_rst;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cfg_bvalid_o <= 1'b0;
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o <= '0;
            ie <= 1'b0;
            oe <= 1'b0;
            fe <= 1'b0;
            intr_o <= 1'b0;
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            cfg_bvalid_o <= wr_acc | (cfg_bvalid_o & ~cfg_bready_i);
            cfg_rvalid_o <= rd_acc | (cfg_rvalid_o & ~cfg_rready_i);
            if (rd_acc) cfg_rdata_o <= {24'h0, (ra == 2'd2) ? status : rd_byte};
            if (ctl_wr) ie <= cfg_wdata_i[4];
            // A same-cycle error event wins over the clear-on-read.
            oe <= (rx_ok & (rx_lvl == DEPTH)) | (oe & ~st_rd);
            fe <= (rx_done & ~rx_s[1]) | (fe & ~st_rd);
            intr_o <= ie & (rx_push | (tx_end & ~tx_load));
            tx_wp <= tx_rst ? '0 : tx_wp + PW'(tx_push);
            tx_rp <= tx_rst ? '0 : tx_rp + PW'(tx_load);
            rx_wp <= rx_rst ? '0 : rx_wp + PW'(rx_push);
            rx_rp <= rx_rst ? '0 : rx_rp + PW'(rx_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= cfg_wdata_i[7:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tx_busy <= 1'b0;
            tx_sh <= '1;
            tx_bit <= '0;
            tx_clk <= '0;
        end else if (tx_load) begin
            tx_busy <= 1'b1;
            tx_sh <= {1'b1, tx_mem[tx_rp[AW-1:0]], 1'b0};
            tx_bit <= '0;
            tx_clk <= '0;
        end else if (tx_busy) begin
            tx_clk <= (tx_clk == BIT_END) ? '0 : tx_clk + 1'b1;
            if (tx_clk == BIT_END) begin
                tx_sh <= {1'b1, tx_sh[9:1]};
                tx_bit <= tx_bit + 1'b1;
                tx_busy <= tx_bit != 4'd9;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_st <= R_IDLE;
            rx_s <= 2'b11;
            rx_q <= 1'b1;
            rx_clk <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
        end else begin
            rx_st <= rx_st_n;
            rx_s <= {rx_s[0], rx_i};
            rx_q <= rx_s[1];
            rx_clk <= (rx_st == R_IDLE || rx_tick) ? '0 : rx_clk + 1'b1;
            if (rx_st == R_DATA && rx_tick) begin
                rx_sh <= {rx_s[1], rx_sh[7:1]};
                rx_bit <= rx_bit + 1'b1;
            end
        end
    end

    // The start bit is re-checked at half a bit; a high line there is treated as a glitch.
    always_comb begin
        rx_st_n = rx_st;
        case (rx_st)
            R_IDLE:  rx_st_n = rx_fall ? R_START : R_IDLE;
            R_START: rx_st_n = !rx_tick ? R_START : (rx_s[1] ? R_IDLE : R_DATA);
            R_DATA:  rx_st_n = (rx_tick && rx_bit == 3'd7) ? R_STOP : R_DATA;
            R_STOP:  rx_st_n = rx_tick ? R_IDLE : R_STOP;
            default: rx_st_n = R_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_lite.sv
// tb_uart_lite: directed self-checking bench for uart_lite
module tb_uart_lite;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cfg_awvalid_i = 1'b0;
    logic [31:0] cfg_awaddr_i = '0;
    logic        cfg_awready_o;
    logic        cfg_wvalid_i = 1'b0;
    logic [31:0] cfg_wdata_i = '0;
    logic [3:0]  cfg_wstrb_i = '0;
    logic        cfg_wready_o;
    logic        cfg_bvalid_o;
    logic [1:0]  cfg_bresp_o;
    logic        cfg_bready_i = 1'b0;
    logic        cfg_arvalid_i = 1'b0;
    logic [31:0] cfg_araddr_i = '0;
    logic        cfg_arready_o;
    logic        cfg_rvalid_o;
    logic [31:0] cfg_rdata_o;
    logic [1:0]  cfg_rresp_o;
    logic        cfg_rready_i = 1'b0;
    logic        rx_i = 1'b1;
    logic        tx_o;
    logic        intr_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int arm_cyc = 0;
    int fall_cyc = -1;
    int intr_hi = 0;
    logic tx_prev = 1'b1;
    logic [31:0] d;

    always #5 clk_i = ~clk_i;

    uart_lite dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_awvalid_i(cfg_awvalid_i), .cfg_awaddr_i(cfg_awaddr_i), .cfg_awready_o(cfg_awready_o),
        .cfg_wvalid_i(cfg_wvalid_i), .cfg_wdata_i(cfg_wdata_i), .cfg_wstrb_i(cfg_wstrb_i),
        .cfg_wready_o(cfg_wready_o),
        .cfg_bvalid_o(cfg_bvalid_o), .cfg_bresp_o(cfg_bresp_o), .cfg_bready_i(cfg_bready_i),
        .cfg_arvalid_i(cfg_arvalid_i), .cfg_araddr_i(cfg_araddr_i), .cfg_arready_o(cfg_arready_o),
        .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_rresp_o(cfg_rresp_o),
        .cfg_rready_i(cfg_rready_i),
        .rx_i(rx_i), .tx_o(tx_o), .intr_o(intr_o)
    );

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (tx_prev && !tx_o && fall_cyc < arm_cyc) fall_cyc = cyc;
        tx_prev = tx_o;
        if (intr_o) intr_hi++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
        int k;
        @(negedge clk_i);
        cfg_awvalid_i = 1'b1; cfg_wvalid_i = 1'b1; cfg_awaddr_i = a; cfg_wdata_i = v;
        cfg_wstrb_i = s; cfg_bready_i = 1'b0;
        #1;
        k = 0;
        while (!cfg_awready_o && k < 20) begin @(negedge clk_i); #1; k++; end
        check("awready", 32'(cfg_awready_o), 32'd1);
        @(negedge clk_i);
        cfg_awvalid_i = 1'b0; cfg_wvalid_i = 1'b0; cfg_bready_i = 1'b1;
        #1;
        check("bvalid", 32'(cfg_bvalid_o), 32'd1);
        @(negedge clk_i);
        cfg_bready_i = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] v);
        int k;
        @(negedge clk_i);
        cfg_arvalid_i = 1'b1; cfg_araddr_i = a;
        #1;
        k = 0;
        while (!cfg_arready_o && k < 20) begin @(negedge clk_i); #1; k++; end
        check("arready", 32'(cfg_arready_o), 32'd1);
        @(negedge clk_i);
        cfg_arvalid_i = 1'b0; cfg_rready_i = 1'b1;
        #1;
        v = cfg_rvalid_o ? cfg_rdata_o : 32'hdead_beef;
        @(negedge clk_i);
        cfg_rready_i = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk_i);
        rx_i = 1'b0;
        repeat (400) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (400) @(negedge clk_i);
        end
        rx_i = stop;
        repeat (400) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (50) @(negedge clk_i);
    endtask

    task automatic at_off(input int m);
        while (cyc < fall_cyc + m) begin @(negedge clk_i); #1; end
    endtask

    initial begin
        int aw_n, w_n, bv_n, base, k;
        logic [7:0] tx_byte;
        logic [7:0] rx_bytes [5];
        rx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        tx_byte = 8'h55;

        repeat (3) @(negedge clk_i);
        #1;
        check("rst_tx", 32'(tx_o), 32'd1);
        check("rst_intr", 32'(intr_o), 32'd0);
        check("rst_bvalid", 32'(cfg_bvalid_o), 32'd0);
        check("rst_rvalid", 32'(cfg_rvalid_o), 32'd0);
        check("rst_rdata", cfg_rdata_o, 32'd0);
        check("rst_resp", 32'({cfg_bresp_o, cfg_rresp_o}), 32'd0);
        rst_i = 1'b1;
        repeat (100) @(negedge clk_i);
        #1;
        check("idle_tx", 32'(tx_o), 32'd1);
        check("idle_intr", 32'(intr_o), 32'd0);
        axi_read(32'h08, d);
        check("status_reset", d, 32'h04);

        send_rx(8'h97, 1'b1);
        axi_read(32'h08, d);
        check("status_rx_valid", d, 32'h05);
        axi_read(32'h00, d);
        check("rx_data", d, 32'h97);
        check("rresp", 32'(cfg_rresp_o), 32'd0);
        axi_read(32'h08, d);
        check("status_rx_drained", d, 32'h04);

        arm_cyc = cyc;
        aw_n = 0; w_n = 0; bv_n = 0;
        @(negedge clk_i);
        cfg_awvalid_i = 1'b1; cfg_wvalid_i = 1'b1; cfg_awaddr_i = 32'h04;
        cfg_wdata_i = 32'h55; cfg_wstrb_i = 4'h1; cfg_bready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (cfg_awready_o) aw_n++;
            if (cfg_wready_o) w_n++;
            if (cfg_bvalid_o) bv_n++;
            @(negedge clk_i);
        end
        check("bresp", 32'(cfg_bresp_o), 32'd0);
        cfg_awvalid_i = 1'b0; cfg_wvalid_i = 1'b0; cfg_bready_i = 1'b1;
        @(negedge clk_i);
        cfg_bready_i = 1'b0;
        #1;
        check("bvalid_cleared", 32'(cfg_bvalid_o), 32'd0);
        repeat (3) @(negedge clk_i);
        #1;
        check("no_second_bvalid", 32'(cfg_bvalid_o), 32'd0);
        check("awready_cycles", 32'(aw_n), 32'd1);
        check("wready_cycles", 32'(w_n), 32'd1);
        check("bvalid_cycles", 32'(bv_n), 32'd5);

        k = 0;
        while (fall_cyc < arm_cyc && k < 100) begin @(negedge clk_i); #1; k++; end
        check("tx_start_seen", 32'(fall_cyc >= arm_cyc), 32'd1);
        at_off(200);
        check("tx_start_mid", 32'(tx_o), 32'd0);
        at_off(399);
        check("tx_start_last", 32'(tx_o), 32'd0);
        at_off(400);
        check("tx_bit0_first", 32'(tx_o), 32'(tx_byte[0]));
        for (int b = 0; b < 8; b++) begin
            at_off(400 * (b + 1) + 200);
            check($sformatf("tx_bit%0d", b), 32'(tx_o), 32'(tx_byte[b]));
        end
        at_off(3599);
        check("tx_bit7_last", 32'(tx_o), 32'(tx_byte[7]));
        at_off(3600);
        check("tx_stop_first", 32'(tx_o), 32'd1);
        at_off(3999);
        check("tx_stop_last", 32'(tx_o), 32'd1);
        at_off(4100);
        check("tx_idle", 32'(tx_o), 32'd1);

        axi_write(32'h0C, 32'h10, 4'h1);
        axi_read(32'h08, d);
        check("status_ie", d, 32'h14);
        base = intr_hi;
        send_rx(8'hA5, 1'b1);
        check("intr_pulse", 32'(intr_hi - base), 32'd1);
        axi_read(32'h00, d);
        check("rx_data_intr", d, 32'hA5);

        base = intr_hi;
        send_rx(8'h3C, 1'b0);
        axi_read(32'h08, d);
        check("status_frame_err", d, 32'h54);
        axi_read(32'h08, d);
        check("status_frame_clr", d, 32'h14);
        check("intr_no_push", 32'(intr_hi - base), 32'd0);

        base = intr_hi;
        for (int i = 0; i < 5; i++) send_rx(rx_bytes[i], 1'b1);
        check("intr_four_pushes", 32'(intr_hi - base), 32'd4);
        axi_read(32'h08, d);
        check("status_overrun", d, 32'h37);
        for (int i = 0; i < 4; i++) begin
            axi_read(32'h00, d);
            check($sformatf("rx_fifo%0d", i), d, 32'(rx_bytes[i]));
        end
        axi_read(32'h08, d);
        check("status_after_drain", d, 32'h14);
        axi_read(32'h00, d);
        check("rx_empty_read", d, 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
